tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
- Autonomous register-write sequencer for the tone generator's 3-bit address / 5-bit data / write-strobe port.
- Holds a small host-loaded pattern memory. Each entry is one register write followed by a delay measured in tick pulses.
- On start it replays the pattern, so melodies and envelopes need no host involvement.
- Sits between host config logic and the signal generator in the top level, running on the fast system clock.

Parameters:
- DEPTH, 16, number of pattern entries (power of two).
- AW, 4, pattern index width, log2(DEPTH).
- DELAY_W, 8, width of the per-entry delay field, in ticks.
- STROBE_LEN, 50, fast-clock cycles write_strobe_out is held high. Must be ≥ 2× clock scale factor so the scaled-clock generator samples it.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  block enable; low freezes all state.
- tick  in  1  one-cycle timebase pulse.
- cfg_we  in  1  pattern memory write enable.
- cfg_addr  in  AW  pattern entry index.
- cfg_wdata  in  8+DELAY_W  entry payload: [2:0] gen address, [7:3] gen data, [8+DELAY_W-1:8] delay.
- len_in  in  AW+1  number of entries to play, 0..DEPTH.
- start  in  1  begin playback pulse.
- stop  in  1  abort playback.
- address_out  out  3  generator address.
- data_out  out  5  generator data.
- write_strobe_out  out  1  generator write strobe.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle end-of-pattern pulse.
- step_idx  out  AW  index of the current entry.

Behaviour:
- Reset: state IDLE; all outputs 0; index, strobe counter and delay counter cleared. Pattern memory contents are not reset.
- en=0: state, counters and outputs hold. tick and start are ignored. stop still forces IDLE.
- FSM states: IDLE, FETCH, WRITE, WAIT, DONE.
- IDLE: start=1 with len_in≠0 → FETCH; step_idx=0; len_in is latched. start with len_in=0 is ignored.
- FETCH: one cycle for the synchronous memory read → WRITE.
- WRITE:
  - address_out and data_out are loaded on entry.
  - write_strobe_out is high for exactly STROBE_LEN cycles, then low → WAIT.
  - address_out and data_out stay stable until the next WRITE.
- WAIT:
  - Delay counter is cleared on entry and counts tick pulses starting the cycle after entry.
  - Exit when count == delay; delay=0 exits after one cycle.
  - On exit: if step_idx+1 == latched length → DONE; else step_idx++ and → FETCH.
- DONE: done=1 for one cycle → IDLE.
- Start-to-first-strobe latency: 2 cycles (start sampled, FETCH, strobe rises).
- stop in any non-IDLE state: → IDLE next cycle, write_strobe_out forced low the same cycle, done not asserted. stop wins over a simultaneous tick or start.
- start while busy: ignored.
- cfg_we while busy: write ignored, so the playing pattern is never modified. When idle, cfg_we writes at the clock edge.
- len_in changes during playback have no effect.
- Index wraps only at latched length, never beyond DEPTH-1.

Optional Feature:
- Macro: TONE_SEQ_LOOP_EN.
- Defined:
  - Adds input loop_in (1 bit).
  - At end of pattern with loop_in=1, done pulses for one cycle, step_idx returns to 0 and the FSM enters FETCH directly, skipping IDLE.
  - loop_in=0 ends playback normally.
  - stop remains the only way to exit a loop.
- Undefined: port absent; playback always ends in DONE → IDLE.

Decomposition:
- Shared package tone_seq_pkg holds:
  - state enum;
  - field offsets and widths: GEN_ADDR_W=3, GEN_DATA_W=5, entry field LSBs;
  - default STROBE_LEN.
- One sub-module, tone_seq_mem: DEPTH × (8+DELAY_W) synchronous-read, single-write RAM with a write-enable gated by busy.

Test Plan:
- Basic play: load 2 entries {addr 1, data 0x0A, delay 3} and {addr 2, data 0x1F, delay 0}; len_in=2; start → two strobes of 50 cycles each with correct address/data; 3 ticks between them; done pulses once; busy falls.
- Zero length: len_in=0, start → busy stays 0, no strobe, no done.
- Stop mid-operation: assert stop during WRITE at strobe cycle 10 → strobe low the same cycle; IDLE next cycle; no done; a restart replays from entry 0.
- Write while busy: cfg_we to entry 0 with new data during playback → playback uses old data; after idle, the write takes effect.
- Enable freeze: en=0 for 20 cycles in WAIT with ticks present → delay counter unchanged; resumes correctly when en=1.
- Loop (TONE_SEQ_LOOP_EN): len_in=1, loop_in=1 → repeated strobes with done on each wrap; stop exits; loop_in=0 ends after the current pass.

Source files
------------

// File: rtl/tone_seq_pkg.sv
// Shared types and entry field layout for the tone register-write sequencer.
package tone_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_WAIT,
        S_DONE
    } state_e;

    localparam int GEN_ADDR_W     = 3;
    localparam int GEN_DATA_W     = 5;
    localparam int ADDR_LSB       = 0;
    localparam int DATA_LSB       = GEN_ADDR_W;
    localparam int DELAY_LSB      = GEN_ADDR_W + GEN_DATA_W;
    localparam int STROBE_LEN_DEF = 50;

endpackage

// File: rtl/tone_seq_mem.sv
// Pattern RAM: synchronous read, single write port gated by the sequencer's busy flag.
module tone_seq_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 16
) (
    input  logic          clk,
    input  logic          cfg_we,
    input  logic          busy,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (cfg_we && !busy) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tone_sequencer.sv
// Replays host-loaded register writes to the tone generator, one delay per entry.
// Build option TONE_SEQ_LOOP_EN adds loop_in for continuous replay.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_FETCH | synchronous pattern read in flight
// S_WRITE | address/data driven, strobe high for STROBE_LEN cycles
// S_WAIT  | counting down the entry delay in ticks
// S_DONE  | one-cycle end-of-pattern pulse
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int DELAY_W    = 8,
    parameter int STROBE_LEN = STROBE_LEN_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    tick,
    input  logic                    cfg_we,
    input  logic [AW-1:0]           cfg_addr,
    input  logic [8+DELAY_W-1:0]    cfg_wdata,
    input  logic [AW:0]             len_in,
    input  logic                    start,
    input  logic                    stop,
`ifdef TONE_SEQ_LOOP_EN
    input  logic                    loop_in,
`endif
    output logic [GEN_ADDR_W-1:0]   address_out,
    output logic [GEN_DATA_W-1:0]   data_out,
    output logic                    write_strobe_out,
    output logic                    busy,
    output logic                    done,
    output logic [AW-1:0]           step_idx
);

    localparam int EW  = 8 + DELAY_W;
    localparam int SCW = $clog2(STROBE_LEN + 1);

    state_e                  state_q, state_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic [AW:0]             len_q, len_d;
    logic [GEN_ADDR_W-1:0]   addr_q, addr_d;
    logic [GEN_DATA_W-1:0]   data_q, data_d;
    logic                    strobe_q, strobe_d;
    logic                    done_q, done_d;
    logic [SCW-1:0]          scnt_q, scnt_d;
    logic [DELAY_W-1:0]      dcnt_q, dcnt_d;
    logic [EW-1:0]           rdata;
    logic                    last_entry;

    assign last_entry = ({1'b0, idx_q} + (AW+1)'(1)) == len_q;

    // Read address follows the next index so the entry is ready by the end of FETCH.
    tone_seq_mem #(.DEPTH(DEPTH), .AW(AW), .W(EW)) u_mem (
        .clk    (clk),
        .cfg_we (cfg_we),
        .busy   (busy),
        .waddr  (cfg_addr),
        .wdata  (cfg_wdata),
        .raddr  (idx_d),
        .rdata  (rdata)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        addr_d   = addr_q;
        data_d   = data_q;
        strobe_d = strobe_q;
        done_d   = done_q;
        scnt_d   = scnt_q;
        dcnt_d   = dcnt_q;
        if (stop && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            strobe_d = 1'b0;
            done_d   = 1'b0;
        end else if (en) begin
            done_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && len_in != '0) begin
                        state_d = S_FETCH;
                        idx_d   = '0;
                        len_d   = len_in;
                    end
                end
                S_FETCH: begin
                    state_d  = S_WRITE;
                    addr_d   = rdata[ADDR_LSB +: GEN_ADDR_W];
                    data_d   = rdata[DATA_LSB +: GEN_DATA_W];
                    dcnt_d   = rdata[DELAY_LSB +: DELAY_W];
                    strobe_d = 1'b1;
                    scnt_d   = SCW'(STROBE_LEN - 1);
                end
                S_WRITE: begin
                    if (scnt_q == '0) begin
                        strobe_d = 1'b0;
                        state_d  = S_WAIT;
                    end else begin
                        scnt_d = scnt_q - SCW'(1);
                    end
                end
                S_WAIT: begin
                    if (dcnt_q == '0) begin
                        if (last_entry) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
`ifdef TONE_SEQ_LOOP_EN
                            if (loop_in) begin
                                state_d = S_FETCH;
                                idx_d   = '0;
                            end
`endif
                        end else begin
                            idx_d   = idx_q + AW'(1);
                            state_d = S_FETCH;
                        end
                    end else if (tick) begin
                        dcnt_d = dcnt_q - DELAY_W'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            scnt_q   <= '0;
            dcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            scnt_q   <= scnt_d;
            dcnt_q   <= dcnt_d;
        end
    end

    // stop must drop the strobe in the same cycle, ahead of the state register.
    assign write_strobe_out = strobe_q & ~stop;
    assign address_out      = addr_q;
    assign data_out         = data_q;
    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;
    assign step_idx         = idx_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer; the loop section is built only with TONE_SEQ_LOOP_EN.
module tb_tone_sequencer;

    logic        clk = 1'b0;
    logic        rst, en, tick, cfg_we, start, stop;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [4:0]  len_in;
    logic [2:0]  address_out;
    logic [4:0]  data_out;
    logic        write_strobe_out, busy, done;
    logic [3:0]  step_idx;
`ifdef TONE_SEQ_LOOP_EN
    logic        loop_in;
`endif

    int total = 0;
    int bad   = 0;
    int n;

    tone_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .tick             (tick),
        .cfg_we           (cfg_we),
        .cfg_addr         (cfg_addr),
        .cfg_wdata        (cfg_wdata),
        .len_in           (len_in),
        .start            (start),
        .stop             (stop),
`ifdef TONE_SEQ_LOOP_EN
        .loop_in          (loop_in),
`endif
        .address_out      (address_out),
        .data_out         (data_out),
        .write_strobe_out (write_strobe_out),
        .busy             (busy),
        .done             (done),
        .step_idx         (step_idx)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        cyc();
        cfg_we = 1'b0;
    endtask

    // Counts strobe-high cycles starting at the current sample point.
    task automatic count_strobe(output int cnt);
        cnt = 0;
        while (write_strobe_out === 1'b1 && cnt < 200) begin
            cnt++;
            cyc();
        end
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 1000) begin
            k++;
            cyc();
        end
        chk(tag, done, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; en = 1; tick = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
        len_in = 0; start = 0; stop = 0;
`ifdef TONE_SEQ_LOOP_EN
        loop_in = 0;
`endif
        repeat (3) cyc();
        rst = 0;
        cyc();
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobe", write_strobe_out, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr", address_out, 3'd0);
        chk("rst_data", data_out, 5'd0);
        chk("rst_step", step_idx, 4'd0);

        // entry0: addr 1, data 0x0A, delay 3; entry1: addr 2, data 0x1F, delay 0
        wr(4'd0, 16'h0351);
        wr(4'd1, 16'h00FA);

        len_in = 2; start = 1;
        cyc();
        start = 0;
        chk("b_fetch_busy", busy, 1'b1);
        chk("b_fetch_strobe", write_strobe_out, 1'b0);
        cyc();
        chk("b0_strobe", write_strobe_out, 1'b1);
        chk("b0_addr", address_out, 3'd1);
        chk("b0_data", data_out, 5'h0A);
        chk("b0_step", step_idx, 4'd0);
        count_strobe(n);
        chk("b0_strobe_len", n[15:0], 16'd50);
        cyc(); cyc();
        for (int k = 0; k < 3; k++) begin
            tick = 1;
            cyc();
            tick = 0;
            chk("b_wait_step", step_idx, 4'd0);
            chk("b_wait_strobe", write_strobe_out, 1'b0);
            cyc();
        end
        chk("b1_fetch_step", step_idx, 4'd1);
        chk("b1_fetch_strobe", write_strobe_out, 1'b0);
        cyc();
        chk("b1_strobe", write_strobe_out, 1'b1);
        chk("b1_addr", address_out, 3'd2);
        chk("b1_data", data_out, 5'h1F);
        count_strobe(n);
        chk("b1_strobe_len", n[15:0], 16'd50);
        chk("b_predone", done, 1'b0);
        chk("b_predone_busy", busy, 1'b1);
        cyc();
        chk("b_done", done, 1'b1);
        cyc();
        chk("b_done_clr", done, 1'b0);
        chk("b_idle", busy, 1'b0);
        chk("b_addr_hold", address_out, 3'd2);

        len_in = 0; start = 1;
        cyc();
        start = 0;
        chk("z_busy0", busy, 1'b0);
        cyc();
        chk("z_busy1", busy, 1'b0);
        chk("z_strobe", write_strobe_out, 1'b0);
        chk("z_done", done, 1'b0);

        len_in = 2; start = 1;
        cyc();
        start = 0;
        cyc();
        chk("s_strobe1", write_strobe_out, 1'b1);
        repeat (9) cyc();
        chk("s_strobe10", write_strobe_out, 1'b1);
        stop = 1;
        #1;
        chk("s_strobe_forced", write_strobe_out, 1'b0);
        chk("s_busy_same", busy, 1'b1);
        cyc();
        stop = 0;
        chk("s_idle", busy, 1'b0);
        chk("s_nodone", done, 1'b0);
        cyc();
        chk("s_nodone2", done, 1'b0);

        len_in = 2; start = 1;
        cyc();
        start = 0;
        chk("r_step", step_idx, 4'd0);
        cyc();
        chk("r_strobe", write_strobe_out, 1'b1);
        chk("r_addr", address_out, 3'd1);
        chk("r_data", data_out, 5'h0A);
        // new entry0: addr 5, data 0x15, delay 3 (must be ignored while busy)
        wr(4'd0, 16'h03AD);
        tick = 1;
        wait_done("r_done_seen");
        tick = 0;
        cyc();
        chk("r_idle", busy, 1'b0);

        len_in = 1; start = 1;
        cyc();
        start = 0;
        cyc();
        chk("wb_old_addr", address_out, 3'd1);
        chk("wb_old_data", data_out, 5'h0A);
        stop = 1;
        cyc();
        stop = 0;
        chk("wb_stopped", busy, 1'b0);

        wr(4'd0, 16'h03AD);
        len_in = 1; start = 1;
        cyc();
        start = 0;
        cyc();
        chk("wi_strobe", write_strobe_out, 1'b1);
        chk("wi_new_addr", address_out, 3'd5);
        chk("wi_new_data", data_out, 5'h15);

        count_strobe(n);
        chk("f_strobe_len", n[15:0], 16'd50);
        cyc();
        tick = 1;
        cyc();
        tick = 0;
        en = 0; tick = 1;
        repeat (20) cyc();
        chk("f_frozen_busy", busy, 1'b1);
        chk("f_frozen_done", done, 1'b0);
        chk("f_frozen_addr", address_out, 3'd5);
        en = 1; tick = 0;
        cyc();
        chk("f_resume_busy", busy, 1'b1);
        tick = 1;
        cyc();
        tick = 0;
        chk("f_tick2_done", done, 1'b0);
        chk("f_tick2_busy", busy, 1'b1);
        tick = 1;
        cyc();
        tick = 0;
        chk("f_tick3_done", done, 1'b0);
        cyc();
        chk("f_done", done, 1'b1);
        cyc();
        chk("f_idle", busy, 1'b0);

`ifdef TONE_SEQ_LOOP_EN
        loop_in = 1; len_in = 1; start = 1;
        cyc();
        start = 0; tick = 1;
        wait_done("l_done1");
        cyc();
        chk("l_wrap_busy", busy, 1'b1);
        chk("l_wrap_step", step_idx, 4'd0);
        wait_done("l_done2");
        stop = 1;
        cyc();
        stop = 0;
        chk("l_stop", busy, 1'b0);
        start = 1;
        cyc();
        start = 0; loop_in = 0;
        wait_done("l_last_done");
        cyc();
        chk("l_end_idle", busy, 1'b0);
        tick = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
